dircc_receive_scheduler: RTL and testbench

//  Sequences the per-device receive handler: round-robin arbitrates NUM_PORTS inbound packet sources, fetches device

---
 rtl/dircc_receive_scheduler_pkg.sv | 35 +++
 rtl/dircc_receive_scheduler_if.sv | 42 ++++
 rtl/dircc_receive_scheduler_rr_arbiter.sv | 30 +++
 rtl/dircc_receive_scheduler.sv | 158 +++++++++++++++
 tb/tb_dircc_receive_scheduler.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dircc_receive_scheduler_pkg.sv
// Shared types for the device receive path: packet and device-state layouts,
// the DONE flag of the device lifecycle, and the receive scheduler states.
package dircc_receive_scheduler_pkg;

    localparam int DIRCC_ADDRESS_WIDTH = 32;

    // Device lifecycle flag: a device in this state accepts no further packets.
    localparam logic [7:0] DIRCC_STATE_DONE = 8'h01;

    typedef struct packed {
        logic [DIRCC_ADDRESS_WIDTH-1:0] dst_address;
        logic [DIRCC_ADDRESS_WIDTH-1:0] src_address;
        logic [15:0]                    payload;
    } packet_data_t;

    typedef struct packed {
        logic [7:0]  dircc_state;
        logic [23:0] user_state;
    } device_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_RD_REQ,
        RX_RD_WAIT,
        RX_DISPATCH,
        RX_WAIT_HDL,
        RX_WRITE,
        RX_ACK
    } rx_sched_state_e;

    function automatic logic state_is_done(input device_state_t s);
        return (s.dircc_state & DIRCC_STATE_DONE) != 8'h00;
    endfunction

endpackage

// File: rtl/dircc_receive_scheduler_if.sv
// Bundle of the scheduler's ingress, device-state memory and handler signals.
// master = scheduler side, slave = surrounding tile (sources, memory, handler).
interface dircc_receive_scheduler_if #(
    parameter int NUM_PORTS = 4
);
    import dircc_receive_scheduler_pkg::*;

    packet_data_t         port_packet [NUM_PORTS];
    logic [NUM_PORTS-1:0] port_valid;
    logic [NUM_PORTS-1:0] port_ack;

    logic                 state_rd_req;
    device_state_t        state_rd_data;
    logic                 state_rd_valid;
    device_state_t        state_wr_data;
    logic                 state_wr_en;

    packet_data_t         hdl_packet;
    device_state_t        hdl_read_state;
    logic                 hdl_receive_done;
    device_state_t        hdl_write_state;
    logic                 hdl_write_valid;
    logic                 hdl_packet_handled;

    logic                 busy;
    logic [15:0]          drop_count;

    modport master (
        input  port_packet, port_valid, state_rd_data, state_rd_valid,
               hdl_write_state, hdl_write_valid, hdl_packet_handled,
        output port_ack, state_rd_req, state_wr_data, state_wr_en,
               hdl_packet, hdl_read_state, hdl_receive_done, busy, drop_count
    );

    modport slave (
        output port_packet, port_valid, state_rd_data, state_rd_valid,
               hdl_write_state, hdl_write_valid, hdl_packet_handled,
        input  port_ack, state_rd_req, state_wr_data, state_wr_en,
               hdl_packet, hdl_read_state, hdl_receive_done, busy, drop_count
    );

endinterface

// File: rtl/dircc_receive_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr, wrapping.
// Purely combinational so the caller decides when the grant is latched.
module dircc_rr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_valid
);

    // Scan from the pointer upward so the last winner gets lowest priority.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            int cand;
            cand = (int'(ptr) + i) % NUM_PORTS;
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/dircc_receive_scheduler.sv
// Receive scheduler: serialises NUM_PORTS packet sources into the device
// receive handler, one packet in flight, with device-state read/write-back.
module dircc_receive_scheduler
    import dircc_receive_scheduler_pkg::*;
#(
    parameter int NUM_PORTS         = 4,
    parameter int ADDRESS_MEM_WIDTH = 32,
    parameter int HANDLER_TIMEOUT   = 64
) (
    input logic                      clk,
    input logic                      reset_n,
    dircc_receive_scheduler_if.master bus
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int TMR_W = $clog2(HANDLER_TIMEOUT + 1);

    // The packet layout is fixed in the shared package; refuse a mismatched build.
    if (ADDRESS_MEM_WIDTH != DIRCC_ADDRESS_WIDTH) begin : g_bad_address_width
        $error("ADDRESS_MEM_WIDTH must match DIRCC_ADDRESS_WIDTH");
    end

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    rx_sched_state_e      state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [IDX_W-1:0]     grant_idx_q;
    logic [NUM_PORTS-1:0] grant_oh_q;
    logic [TMR_W-1:0]     timer_q;
    logic                 have_wr_q;
    device_state_t        wr_data_q;
    packet_data_t         hdl_packet_q;
    device_state_t        hdl_read_state_q;
    logic [15:0]          drop_q;

    logic [NUM_PORTS-1:0] arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_valid;

    logic rd_req, rcv_done, wr_en, ack, drop_inc;

    dircc_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_arb (
        .req         (bus.port_valid),
        .ptr         (rr_ptr_q),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // State register; reset abandons any transaction without ack or write-back.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= RX_IDLE;
        else          state_q <= state_d;
    end

    // Next state and one-cycle strobes, decoded from the current state.
    always_comb begin
        state_d  = state_q;
        rd_req   = 1'b0;
        rcv_done = 1'b0;
        wr_en    = 1'b0;
        ack      = 1'b0;
        drop_inc = 1'b0;
        case (state_q)
            RX_IDLE:     if (arb_valid) state_d = RX_RD_REQ;
            RX_RD_REQ: begin
                rd_req  = 1'b1;
                state_d = RX_RD_WAIT;
            end
            RX_RD_WAIT: begin
                if (bus.state_rd_valid) begin
                    if (state_is_done(bus.state_rd_data)) begin
                        drop_inc = 1'b1;
                        state_d  = RX_ACK;
                    end else begin
                        state_d  = RX_DISPATCH;
                    end
                end
            end
            RX_DISPATCH: begin
                rcv_done = 1'b1;
                state_d  = RX_WAIT_HDL;
            end
            RX_WAIT_HDL: begin
                if (bus.hdl_packet_handled) begin
                    state_d = (have_wr_q || bus.hdl_write_valid) ? RX_WRITE : RX_ACK;
                end else if (timer_q == TMR_W'(HANDLER_TIMEOUT - 1)) begin
                    drop_inc = 1'b1;
                    state_d  = RX_ACK;
                end
            end
            RX_WRITE: begin
                wr_en   = 1'b1;
                state_d = RX_ACK;
            end
            RX_ACK: begin
                ack     = 1'b1;
                state_d = RX_IDLE;
            end
            default:     state_d = RX_IDLE;
        endcase
    end

    // Grant/packet/state capture, handler timer, rr pointer and drop counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr_q         <= '0;
            grant_idx_q      <= '0;
            grant_oh_q       <= '0;
            timer_q          <= '0;
            have_wr_q        <= 1'b0;
            wr_data_q        <= '0;
            hdl_packet_q     <= '0;
            hdl_read_state_q <= '0;
            drop_q           <= '0;
        end else begin
            if (state_q == RX_IDLE && arb_valid) begin
                grant_idx_q  <= arb_idx;
                grant_oh_q   <= arb_grant;
                hdl_packet_q <= bus.port_packet[arb_idx];
            end
            if (state_q == RX_RD_WAIT && bus.state_rd_valid) begin
                hdl_read_state_q <= bus.state_rd_data;
            end
            if (state_q == RX_DISPATCH) begin
                timer_q   <= '0;
                have_wr_q <= 1'b0;
            end
            if (state_q == RX_WAIT_HDL) begin
                timer_q <= timer_q + TMR_W'(1);
                if (bus.hdl_write_valid) begin
                    wr_data_q <= bus.hdl_write_state;
                    have_wr_q <= 1'b1;
                end
            end
            if (state_q == RX_ACK) begin
                rr_ptr_q <= (grant_idx_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx_q + IDX_W'(1);
            end
            if (drop_inc) drop_q <= sat_inc16(drop_q);
        end
    end

    assign bus.state_rd_req     = rd_req;
    assign bus.hdl_receive_done = rcv_done;
    assign bus.state_wr_en      = wr_en;
    assign bus.port_ack         = ack ? grant_oh_q : '0;
    assign bus.state_wr_data    = wr_data_q;
    assign bus.hdl_packet       = hdl_packet_q;
    assign bus.hdl_read_state   = hdl_read_state_q;
    assign bus.busy             = (state_q != RX_IDLE);
    assign bus.drop_count       = drop_q;

endmodule

// File: tb/tb_dircc_receive_scheduler.sv
// Bench for dircc_receive_scheduler: the bench plays packet sources, device
// state memory and handler, and compares each transaction's event timeline
// against a timeline computed from the scheduler's documented rules.
`timescale 1ns/1ps
module tb_dircc_receive_scheduler;
    import dircc_receive_scheduler_pkg::*;

    localparam int NP = 4;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dircc_receive_scheduler_if #(.NUM_PORTS(NP)) bus();

    dircc_receive_scheduler #(
        .NUM_PORTS(NP), .ADDRESS_MEM_WIDTH(32), .HANDLER_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Environment behaviour knobs
    int rd_lat = 1, hdl_h = 1, hdl_mode = 0;   // mode 0 valid+handled, 1 handled only, 2 never, 3 valid then handled 2 later
    device_state_t mem_state, hdl_result;
    bit refill = 0;
    int rd_cd = -1, hdl_age = -1;
    int overlap = 0;

    // Event logs
    int ack_cyc_q[$], ack_port_q[$], rdreq_q[$], done_cyc_q[$], wr_cyc_q[$];
    packet_data_t done_pkt_q[$];
    device_state_t done_st_q[$], wr_data_q[$];

    // Reference model state
    int model_ptr = 0;
    int model_drop = 0;

    function automatic packet_data_t rand_pkt();
        packet_data_t p;
        p.dst_address = $urandom;
        p.src_address = $urandom;
        p.payload     = 16'($urandom);
        return p;
    endfunction

    function automatic device_state_t rand_state(input bit done);
        device_state_t s;
        s.dircc_state = (8'($urandom) & ~DIRCC_STATE_DONE) | (done ? DIRCC_STATE_DONE : 8'h00);
        s.user_state  = 24'($urandom);
        return s;
    endfunction

    // Round-robin rule: first requesting index at or after ptr, wrapping.
    function automatic int rr_pick(input logic [NP-1:0] mask, input int ptr);
        for (int i = 0; i < NP; i++) begin
            if (mask[(ptr + i) % NP]) return (ptr + i) % NP;
        end
        return -1;
    endfunction

    // Expected timeline of one transaction granted in cycle t.
    function automatic void predict(input int t, input int l, input int h, input int mode, input bit dn,
                                    output int rd, output int disp, output int wr, output int ackc, output int drops);
        rd = t + 1; disp = -1; wr = -1; drops = 0;
        if (dn) begin
            ackc = t + 2 + l; drops = 1;
        end else begin
            disp = t + 2 + l;
            case (mode)
                0: begin wr = disp + h + 1; ackc = disp + h + 2; end
                1: ackc = disp + h + 1;
                3: begin wr = disp + h + 3; ackc = disp + h + 4; end
                default: begin ackc = disp + TO + 1; drops = 1; end
            endcase
        end
    endfunction

    task automatic clear_logs();
        ack_cyc_q.delete(); ack_port_q.delete(); rdreq_q.delete(); done_cyc_q.delete();
        wr_cyc_q.delete(); done_pkt_q.delete(); done_st_q.delete(); wr_data_q.delete();
        overlap = 0;
    endtask

    // One clock: sample DUT outputs at negedge, then drive this cycle's inputs.
    task automatic cycle();
        int n;
        @(negedge clk);
        cyc++;
        n = int'(bus.state_rd_req) + int'(bus.hdl_receive_done) + int'(bus.state_wr_en) + $countones(bus.port_ack);
        if (n > 1) overlap++;
        bus.state_rd_valid = 1'b0;
        if (rd_cd > 0) begin
            rd_cd--;
            if (rd_cd == 0) begin
                bus.state_rd_valid = 1'b1;
                bus.state_rd_data  = mem_state;
                rd_cd = -1;
            end
        end
        if (bus.state_rd_req) begin
            rdreq_q.push_back(cyc);
            rd_cd = rd_lat;
        end
        bus.hdl_write_valid    = 1'b0;
        bus.hdl_packet_handled = 1'b0;
        bus.hdl_write_state    = hdl_result;
        if (hdl_age >= 0) begin
            hdl_age++;
            case (hdl_mode)
                0: if (hdl_age == hdl_h) begin
                       bus.hdl_write_valid = 1'b1; bus.hdl_packet_handled = 1'b1; hdl_age = -1;
                   end
                1: if (hdl_age == hdl_h) begin
                       bus.hdl_packet_handled = 1'b1; hdl_age = -1;
                   end
                3: begin
                       if (hdl_age == hdl_h) bus.hdl_write_valid = 1'b1;
                       if (hdl_age == hdl_h + 2) begin bus.hdl_packet_handled = 1'b1; hdl_age = -1; end
                   end
                default: ;
            endcase
        end
        if (bus.hdl_receive_done) begin
            done_cyc_q.push_back(cyc);
            done_pkt_q.push_back(bus.hdl_packet);
            done_st_q.push_back(bus.hdl_read_state);
            hdl_age = 0;
        end
        if (bus.state_wr_en) begin
            wr_cyc_q.push_back(cyc);
            wr_data_q.push_back(bus.state_wr_data);
        end
        for (int i = 0; i < NP; i++) begin
            if (bus.port_ack[i]) begin
                ack_cyc_q.push_back(cyc);
                ack_port_q.push_back(i);
                if (refill) bus.port_packet[i] = rand_pkt();
                else        bus.port_valid[i]  = 1'b0;
            end
        end
    endtask

    task automatic wait_acks(input int n, input int budget, output bit expired);
        int k;
        k = 0;
        expired = 1'b0;
        while (ack_cyc_q.size() < n) begin
            if (k >= budget) begin expired = 1'b1; break; end
            cycle();
            k++;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.port_valid = '0;
        rd_cd = -1; hdl_age = -1;
        cycle(); cycle();
        reset_n = 1'b1;
        model_ptr = 0; model_drop = 0;
        cycle();
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
        tests++; if (bus.drop_count !== 16'd0) begin fails++; $display("FAIL reset_drop: got %0d expected 0", bus.drop_count); end
        tests++; if (bus.state_rd_req !== 1'b0) begin fails++; $display("FAIL reset_rd_req: got %0b expected 0", bus.state_rd_req); end
        tests++; if (bus.hdl_receive_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b expected 0", bus.hdl_receive_done); end
        tests++; if (bus.state_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %0b expected 0", bus.state_wr_en); end
        tests++; if (bus.port_ack !== '0) begin fails++; $display("FAIL reset_ack: got %b expected 0", bus.port_ack); end
        tests++; if (bus.hdl_packet !== '0) begin fails++; $display("FAIL reset_hdl_packet: got %h expected 0", bus.hdl_packet); end
        tests++; if (bus.hdl_read_state !== '0) begin fails++; $display("FAIL reset_hdl_state: got %h expected 0", bus.hdl_read_state); end
    endtask

    // One transaction from the given source mask; full timeline and data check.
    task automatic test_transaction(input logic [NP-1:0] mask, input int l, input int h, input int mode,
                                    input bit dn, input string name);
        packet_data_t pk [NP];
        int g, t, e_rd, e_disp, e_wr, e_ack, e_drops;
        bit exp;
        for (int i = 0; i < NP; i++) begin
            pk[i] = rand_pkt();
            bus.port_packet[i] = pk[i];
        end
        rd_lat = l; hdl_h = h; hdl_mode = mode; refill = 0;
        mem_state = rand_state(dn); hdl_result = rand_state(0);
        clear_logs();
        g = rr_pick(mask, model_ptr);
        bus.port_valid = mask;
        t = cyc;
        predict(t, l, h, mode, dn, e_rd, e_disp, e_wr, e_ack, e_drops);
        wait_acks(1, TO + 40, exp);
        bus.port_valid = '0;
        tests++;
        if (exp) begin
            fails++; $display("FAIL %s_ack_timeout: got no ack expected ack at %0d", name, e_ack);
        end else begin
            tests++; if (ack_port_q[0] != g) begin fails++; $display("FAIL %s_ack_port: got %0d expected %0d", name, ack_port_q[0], g); end
            tests++; if (ack_cyc_q[0] != e_ack) begin fails++; $display("FAIL %s_ack_cycle: got %0d expected %0d", name, ack_cyc_q[0] - t, e_ack - t); end
            tests++; if (rdreq_q.size() != 1 || rdreq_q[0] != e_rd) begin fails++; $display("FAIL %s_rd_req: got %0d reqs expected 1 at T+1", name, rdreq_q.size()); end
            tests++; if (done_cyc_q.size() != (e_disp >= 0 ? 1 : 0)) begin fails++; $display("FAIL %s_done_count: got %0d expected %0d", name, done_cyc_q.size(), e_disp >= 0 ? 1 : 0); end
            if (e_disp >= 0 && done_cyc_q.size() == 1) begin
                tests++; if (done_cyc_q[0] != e_disp) begin fails++; $display("FAIL %s_done_cycle: got T+%0d expected T+%0d", name, done_cyc_q[0] - t, e_disp - t); end
                tests++; if (done_pkt_q[0] !== pk[g]) begin fails++; $display("FAIL %s_hdl_packet: got %h expected %h", name, done_pkt_q[0], pk[g]); end
                tests++; if (done_st_q[0] !== mem_state) begin fails++; $display("FAIL %s_hdl_state: got %h expected %h", name, done_st_q[0], mem_state); end
            end
            tests++; if (wr_cyc_q.size() != (e_wr >= 0 ? 1 : 0)) begin fails++; $display("FAIL %s_wr_count: got %0d expected %0d", name, wr_cyc_q.size(), e_wr >= 0 ? 1 : 0); end
            if (e_wr >= 0 && wr_cyc_q.size() == 1) begin
                tests++; if (wr_cyc_q[0] != e_wr) begin fails++; $display("FAIL %s_wr_cycle: got T+%0d expected T+%0d", name, wr_cyc_q[0] - t, e_wr - t); end
                tests++; if (wr_data_q[0] !== hdl_result) begin fails++; $display("FAIL %s_wr_data: got %h expected %h", name, wr_data_q[0], hdl_result); end
            end
            model_drop = model_drop + e_drops;
            tests++; if (bus.drop_count !== 16'(model_drop)) begin fails++; $display("FAIL %s_drop_count: got %0d expected %0d", name, bus.drop_count, model_drop); end
            tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL %s_busy_at_ack: got %0b expected 1", name, bus.busy); end
            tests++; if (overlap != 0) begin fails++; $display("FAIL %s_strobe_overlap: got %0d expected 0", name, overlap); end
            model_ptr = (g + 1) % NP;
        end
        cycle();
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL %s_idle_after_ack: got busy %0b expected 0", name, bus.busy); end
    endtask

    task automatic test_single_port0();  test_transaction(4'b0001, 1, 1, 0, 1'b0, "single_p0"); endtask
    task automatic test_done_state();    test_transaction(4'b0100, 1, 1, 0, 1'b1, "done_state"); endtask
    task automatic test_timeout();       test_transaction(4'b1000, 1, 1, 2, 1'b0, "timeout"); endtask
    task automatic test_latency5_no_write(); test_transaction(4'b0010, 5, 2, 1, 1'b0, "lat5_nowr"); endtask

    task automatic test_random(input int iters);
        logic [NP-1:0] mask;
        int mode;
        for (int it = 0; it < iters; it++) begin
            mask = NP'($urandom_range(1, (1 << NP) - 1));
            case ($urandom_range(0, 2))
                0: mode = 0;
                1: mode = 1;
                default: mode = 3;
            endcase
            test_transaction(mask, $urandom_range(1, 5), $urandom_range(1, 4), mode,
                             $urandom_range(0, 3) == 0, "random");
        end
    endtask

    // Source withdraws valid and changes its packet right after the grant.
    task automatic test_valid_drop();
        packet_data_t orig;
        int t;
        bit exp;
        orig = rand_pkt();
        bus.port_packet[1] = orig;
        rd_lat = 1; hdl_h = 1; hdl_mode = 0; refill = 0;
        mem_state = rand_state(0); hdl_result = rand_state(0);
        clear_logs();
        bus.port_valid = 4'b0010;
        t = cyc;
        cycle();
        bus.port_valid = '0;
        bus.port_packet[1] = ~orig;
        wait_acks(1, 40, exp);
        tests++;
        if (exp) begin
            fails++; $display("FAIL valid_drop_timeout: got no ack expected ack at T+6");
        end else begin
            tests++; if (ack_port_q[0] != 1 || ack_cyc_q[0] != t + 6) begin fails++; $display("FAIL valid_drop_ack: got port %0d at T+%0d expected port 1 at T+6", ack_port_q[0], ack_cyc_q[0] - t); end
            tests++; if (done_pkt_q.size() != 1 || done_pkt_q[0] !== orig) begin fails++; $display("FAIL valid_drop_packet: got %0d dispatches expected latched packet %h", done_pkt_q.size(), orig); end
            model_ptr = 2;
        end
        cycle();
    endtask

    // All sources continuously valid: strict rotation, one transaction at a time.
    task automatic test_round_robin();
        int t, p, e_ack;
        bit exp;
        do_reset();
        rd_lat = 1; hdl_h = 1; hdl_mode = 0; refill = 1;
        mem_state = rand_state(0); hdl_result = rand_state(0);
        for (int i = 0; i < NP; i++) bus.port_packet[i] = rand_pkt();
        clear_logs();
        bus.port_valid = '1;
        t = cyc;
        wait_acks(8, 200, exp);
        bus.port_valid = '0;
        refill = 0;
        tests++;
        if (exp) begin
            fails++; $display("FAIL rr_timeout: got %0d acks expected 8", ack_cyc_q.size());
        end else begin
            p = model_ptr;
            e_ack = t + 6;
            for (int k = 0; k < 8; k++) begin
                tests++; if (ack_port_q[k] != rr_pick('1, p)) begin fails++; $display("FAIL rr_order_%0d: got port %0d expected %0d", k, ack_port_q[k], rr_pick('1, p)); end
                tests++; if (ack_cyc_q[k] != e_ack) begin fails++; $display("FAIL rr_cycle_%0d: got %0d expected %0d", k, ack_cyc_q[k], e_ack); end
                p = (rr_pick('1, p) + 1) % NP;
                e_ack = e_ack + 7;
            end
            tests++; if (rdreq_q.size() != 8 || wr_cyc_q.size() != 8) begin fails++; $display("FAIL rr_one_in_flight: got %0d reads %0d writes expected 8 each", rdreq_q.size(), wr_cyc_q.size()); end
            tests++; if (overlap != 0) begin fails++; $display("FAIL rr_strobe_overlap: got %0d expected 0", overlap); end
            model_ptr = p;
        end
        cycle();
    endtask

    // Reset while the handler is working: transaction abandoned, then redone.
    task automatic test_reset_mid();
        packet_data_t pk;
        int t, e_rd, e_disp, e_wr, e_ack, e_drops, k;
        bit exp;
        pk = rand_pkt();
        bus.port_packet[2] = pk;
        rd_lat = 1; hdl_h = 1; hdl_mode = 2; refill = 0;
        mem_state = rand_state(0); hdl_result = rand_state(0);
        clear_logs();
        bus.port_valid = 4'b0100;
        k = 0;
        while (done_cyc_q.size() == 0 && k < 20) begin cycle(); k++; end
        tests++;
        if (done_cyc_q.size() == 0) begin
            fails++; $display("FAIL reset_mid_no_dispatch: got none expected a dispatch");
        end
        cycle(); cycle();
        reset_n = 1'b0;
        cycle();
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_mid_busy: got %0b expected 0", bus.busy); end
        tests++; if ({bus.state_rd_req, bus.hdl_receive_done, bus.state_wr_en, bus.port_ack} !== '0) begin fails++; $display("FAIL reset_mid_strobes: got %b expected 0", {bus.state_rd_req, bus.hdl_receive_done, bus.state_wr_en, bus.port_ack}); end
        tests++; if (ack_cyc_q.size() != 0 || wr_cyc_q.size() != 0) begin fails++; $display("FAIL reset_mid_abandon: got %0d acks %0d writes expected 0", ack_cyc_q.size(), wr_cyc_q.size()); end
        tests++; if (bus.drop_count !== 16'd0) begin fails++; $display("FAIL reset_mid_drop: got %0d expected 0", bus.drop_count); end
        reset_n = 1'b1;
        hdl_mode = 0; hdl_age = -1; rd_cd = -1;
        model_ptr = 0; model_drop = 0;
        clear_logs();
        t = cyc;
        predict(t, 1, 1, 0, 1'b0, e_rd, e_disp, e_wr, e_ack, e_drops);
        wait_acks(1, 40, exp);
        bus.port_valid = '0;
        tests++;
        if (exp) begin
            fails++; $display("FAIL reset_mid_regrant: got no ack expected ack at T+6");
        end else begin
            tests++; if (ack_port_q[0] != 2 || ack_cyc_q[0] != e_ack) begin fails++; $display("FAIL reset_mid_ack: got port %0d at T+%0d expected port 2 at T+%0d", ack_port_q[0], ack_cyc_q[0] - t, e_ack - t); end
            tests++; if (done_pkt_q.size() != 1 || done_pkt_q[0] !== pk) begin fails++; $display("FAIL reset_mid_packet: got %0d dispatches expected same packet %h", done_pkt_q.size(), pk); end
            tests++; if (wr_data_q.size() != 1 || wr_data_q[0] !== hdl_result) begin fails++; $display("FAIL reset_mid_write: got %0d writes expected 1 of %h", wr_data_q.size(), hdl_result); end
        end
        cycle();
    endtask

    initial begin
        bus.port_valid         = '0;
        bus.state_rd_valid     = 1'b0;
        bus.state_rd_data      = '0;
        bus.hdl_write_state    = '0;
        bus.hdl_write_valid    = 1'b0;
        bus.hdl_packet_handled = 1'b0;
        for (int i = 0; i < NP; i++) bus.port_packet[i] = '0;
        mem_state = '0;
        hdl_result = '0;
        test_reset();
        test_single_port0();
        test_done_state();
        test_timeout();
        test_latency5_no_write();
        test_valid_drop();
        test_round_robin();
        test_random(12);
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
